// File: rtl/bit_packer_if.sv
// Code-in / packed-word-out bundle for bit_packer; no backpressure signals exist in either direction.
// With BIT_PACKER_STATS_EN defined the bundle also carries the total_bits and word_count counters.
interface bit_packer_if;
    logic        enable;
    logic [31:0] val;
    logic [31:0] size_of_bit;
    logic        flush_bit;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        proto_err;
`ifdef BIT_PACKER_STATS_EN
    logic [31:0] total_bits;
    logic [31:0] word_count;

    modport master (
        output enable, val, size_of_bit, flush_bit,
        input  out_valid, out_data, out_bytes, out_last, proto_err, total_bits, word_count
    );
    modport slave (
        input  enable, val, size_of_bit, flush_bit,
        output out_valid, out_data, out_bytes, out_last, proto_err, total_bits, word_count
    );
`else
    modport master (
        output enable, val, size_of_bit, flush_bit,
        input  out_valid, out_data, out_bytes, out_last, proto_err
    );
    modport slave (
        input  enable, val, size_of_bit, flush_bit,
        output out_valid, out_data, out_bytes, out_last, proto_err
    );
`endif
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length codes MSB-first into 32-bit words; one-cycle latency, flush emits a padded last word.
// No backpressure either way. Define BIT_PACKER_STATS_EN to add total_bits/word_count counters.
module bit_packer #(
    parameter logic PAD_BIT = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    bit_packer_if.slave  bus
);

    typedef enum logic {ACCUM, FLUSH_TAIL} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  fill_q, fill_d;
    logic [31:0] tail_data_q, tail_data_d;
    logic [2:0]  tail_bytes_q, tail_bytes_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        out_last_q, out_last_d;
    logic        proto_err_q, proto_err_d;
`ifdef BIT_PACKER_STATS_EN
    logic [31:0] total_bits_q, total_bits_d;
    logic [31:0] word_count_q, word_count_d;
`endif

    logic        oversize;
    logic [5:0]  s_len;
    logic [6:0]  align_sh;
    logic [6:0]  total;
    logic [6:0]  tail_len;
    logic [31:0] masked;
    logic [63:0] placed;
    logic [63:0] merged;

    // Unused low bits of a final word take PAD_BIT; accumulator bits below the code are always zero.
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [6:0] t);
        return w | ({32{PAD_BIT}} & (32'hFFFF_FFFF >> t));
    endfunction

    function automatic logic [2:0] byte_count(input logic [6:0] t);
        logic [6:0] r;
        r = t + 7'd7;
        return r[5:3];
    endfunction

    always_comb begin
        oversize = (bus.size_of_bit > 32'd32);
        s_len    = oversize ? 6'd32 : bus.size_of_bit[5:0];
        masked   = bus.val & ~(32'hFFFF_FFFF << s_len);
        align_sh = 7'd32 - {1'b0, s_len};
        placed   = ({masked, 32'h0} << align_sh) >> fill_q;
        merged   = acc_q | placed;
        total    = {2'b00, fill_q} + {1'b0, s_len};
        tail_len = total - 7'd32;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        tail_data_d  = tail_data_q;
        tail_bytes_d = tail_bytes_q;
        out_valid_d  = 1'b0;
        out_data_d   = 32'h0;
        out_bytes_d  = 3'd0;
        out_last_d   = 1'b0;
        proto_err_d  = proto_err_q;
`ifdef BIT_PACKER_STATS_EN
        total_bits_d = total_bits_q;
`endif
        case (state_q)
            ACCUM: begin
                if (bus.enable) begin
                    if (oversize) proto_err_d = 1'b1;
`ifdef BIT_PACKER_STATS_EN
                    total_bits_d = total_bits_q + {26'h0, s_len};
`endif
                    if (bus.flush_bit) begin
                        acc_d  = 64'h0;
                        fill_d = 5'd0;
                        if (total > 7'd32) begin
                            // Two words to go: full word now, padded tail from FLUSH_TAIL next cycle.
                            out_valid_d  = 1'b1;
                            out_data_d   = merged[63:32];
                            out_bytes_d  = 3'd4;
                            tail_data_d  = pad_word(merged[31:0], tail_len);
                            tail_bytes_d = byte_count(tail_len);
                            state_d      = FLUSH_TAIL;
                        end else if (total != 7'd0) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pad_word(merged[63:32], total);
                            out_bytes_d = byte_count(total);
                            out_last_d  = 1'b1;
                        end
                    end else if (total >= 7'd32) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged[63:32];
                        out_bytes_d = 3'd4;
                        acc_d       = merged << 32;
                        fill_d      = total[4:0];
                    end else begin
                        acc_d  = merged;
                        fill_d = total[4:0];
                    end
                end
            end
            FLUSH_TAIL: begin
                out_valid_d = 1'b1;
                out_data_d  = tail_data_q;
                out_bytes_d = tail_bytes_q;
                out_last_d  = 1'b1;
                state_d     = ACCUM;
                if (bus.enable) proto_err_d = 1'b1;
            end
            default: state_d = ACCUM;
        endcase
`ifdef BIT_PACKER_STATS_EN
        word_count_d = word_count_q + {31'h0, out_valid_d};
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= 64'h0;
            fill_q       <= 5'd0;
            tail_data_q  <= 32'h0;
            tail_bytes_q <= 3'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            out_bytes_q  <= 3'd0;
            out_last_q   <= 1'b0;
            proto_err_q  <= 1'b0;
`ifdef BIT_PACKER_STATS_EN
            total_bits_q <= 32'h0;
            word_count_q <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            tail_data_q  <= tail_data_d;
            tail_bytes_q <= tail_bytes_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_last_q   <= out_last_d;
            proto_err_q  <= proto_err_d;
`ifdef BIT_PACKER_STATS_EN
            total_bits_q <= total_bits_d;
            word_count_q <= word_count_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_bytes = out_bytes_q;
    assign bus.out_last  = out_last_q;
    assign bus.proto_err = proto_err_q;
`ifdef BIT_PACKER_STATS_EN
    assign bus.total_bits = total_bits_q;
    assign bus.word_count = word_count_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: inputs change and outputs are sampled on the falling clock edge.
module tb_bit_packer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bit_packer_if bp ();

    bit_packer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, out_data, out_bytes, out_last}
    function automatic logic [36:0] pk(input logic v, input logic [31:0] d, input logic [2:0] b, input logic l);
        return {v, d, b, l};
    endfunction

    function automatic logic [36:0] obs();
        return {bp.out_valid, bp.out_data, bp.out_bytes, bp.out_last};
    endfunction

    // Present one input cycle, then return on the next falling edge with that cycle's result visible.
    task automatic step(input logic en, input logic [31:0] v, input logic [31:0] s, input logic fl);
        bp.enable      = en;
        bp.val         = v;
        bp.size_of_bit = s;
        bp.flush_bit   = fl;
        @(negedge clk);
        bp.enable      = 1'b0;
        bp.flush_bit   = 1'b0;
        bp.val         = 32'h0;
        bp.size_of_bit = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bp.enable      = 1'b1;
        bp.val         = 32'hFFFF_FFFF;
        bp.size_of_bit = 32'd40;
        bp.flush_bit   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bp.enable    = 1'b0;
        bp.flush_bit = 1'b0;
        rst          = 1'b0;
        n_checks++;
        if (obs() !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs(), 37'h0);
        end
        n_checks++;
        if (bp.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_proto_err: got %b want 0", bp.proto_err);
        end
    endtask

    task automatic test_pack_bytes();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_00AB, 32'd8, 1'b0);
            n_checks++;
            if (bp.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pack_partial_%0d: out_valid got %b want 0", i, bp.out_valid);
            end
        end
        step(1'b1, 32'h0000_00AB, 32'd8, 1'b0);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hABAB_ABAB, 3'd4, 1'b0)) begin
            n_fail++;
            $display("FAIL pack_word: got %h want %h", obs(), pk(1'b1, 32'hABAB_ABAB, 3'd4, 1'b0));
        end
        step(1'b0, 32'h0, 32'd0, 1'b0);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_idle: out_valid got %b want 0", bp.out_valid);
        end
    endtask

    task automatic test_flush_short();
        step(1'b1, 32'hFFFF_FFFD, 32'd3, 1'b0);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_append: out_valid got %b want 0", bp.out_valid);
        end
        step(1'b1, 32'h0, 32'd0, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hA000_0000, 3'd1, 1'b1)) begin
            n_fail++;
            $display("FAIL short_flush: got %h want %h", obs(), pk(1'b1, 32'hA000_0000, 3'd1, 1'b1));
        end
    endtask

    task automatic test_flush_split();
        step(1'b1, 32'h0001_2345, 32'd20, 1'b0);
        step(1'b1, 32'h000F_FFFF, 32'd20, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'h1234_5FFF, 3'd4, 1'b0)) begin
            n_fail++;
            $display("FAIL split_full: got %h want %h", obs(), pk(1'b1, 32'h1234_5FFF, 3'd4, 1'b0));
        end
        step(1'b0, 32'h0, 32'd0, 1'b0);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFF00_0000, 3'd1, 1'b1)) begin
            n_fail++;
            $display("FAIL split_tail: got %h want %h", obs(), pk(1'b1, 32'hFF00_0000, 3'd1, 1'b1));
        end
        step(1'b0, 32'h0, 32'd0, 1'b0);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL split_after: out_valid got %b want 0", bp.out_valid);
        end
    endtask

    task automatic test_boundaries();
        step(1'b1, 32'h1234_5678, 32'd32, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'h1234_5678, 3'd4, 1'b1)) begin
            n_fail++;
            $display("FAIL exact32_flush: got %h want %h", obs(), pk(1'b1, 32'h1234_5678, 3'd4, 1'b1));
        end
        step(1'b1, 32'h0000_01FF, 32'd9, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFF80_0000, 3'd2, 1'b1)) begin
            n_fail++;
            $display("FAIL nine_bit_flush: got %h want %h", obs(), pk(1'b1, 32'hFF80_0000, 3'd2, 1'b1));
        end
        step(1'b1, 32'h01FF_FFFF, 32'd25, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFFFF_FF80, 3'd4, 1'b1)) begin
            n_fail++;
            $display("FAIL bits25_flush: got %h want %h", obs(), pk(1'b1, 32'hFFFF_FF80, 3'd4, 1'b1));
        end
        step(1'b1, 32'h7FFF_FFFF, 32'd31, 1'b0);
        step(1'b1, 32'h0, 32'd1, 1'b0);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFFFF_FFFE, 3'd4, 1'b0)) begin
            n_fail++;
            $display("FAIL fill31_plus1: got %h want %h", obs(), pk(1'b1, 32'hFFFF_FFFE, 3'd4, 1'b0));
        end
        step(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_slice: out_valid got %b want 0", bp.out_valid);
        end
    endtask

    task automatic test_enable_low_flush();
        step(1'b1, 32'h0000_003C, 32'd8, 1'b0);
        step(1'b0, 32'h0, 32'd0, 1'b1);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_enable: out_valid got %b want 0", bp.out_valid);
        end
        step(1'b1, 32'h0, 32'd0, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'h3C00_0000, 3'd1, 1'b1)) begin
            n_fail++;
            $display("FAIL flush_kept_bits: got %h want %h", obs(), pk(1'b1, 32'h3C00_0000, 3'd1, 1'b1));
        end
    endtask

    task automatic test_proto_err();
        step(1'b1, 32'h0, 32'd20, 1'b0);
        step(1'b1, 32'h000F_FFFF, 32'd20, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'h0000_0FFF, 3'd4, 1'b0) || bp.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_full: got %h err %b want %h err 0", obs(), bp.proto_err, pk(1'b1, 32'h0000_0FFF, 3'd4, 1'b0));
        end
        step(1'b1, 32'hAAAA_AAAA, 32'd32, 1'b0);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFF00_0000, 3'd1, 1'b1)) begin
            n_fail++;
            $display("FAIL perr_tail: got %h want %h", obs(), pk(1'b1, 32'hFF00_0000, 3'd1, 1'b1));
        end
        n_checks++;
        if (bp.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_set: got %b want 1", bp.proto_err);
        end
        step(1'b0, 32'h0, 32'd0, 1'b0);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_dropped: out_valid got %b want 0", bp.out_valid);
        end
        step(1'b1, 32'h0000_000F, 32'd4, 1'b1);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hF000_0000, 3'd1, 1'b1) || bp.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_sticky: got %h err %b want %h err 1", obs(), bp.proto_err, pk(1'b1, 32'hF000_0000, 3'd1, 1'b1));
        end
        do_reset();
        n_checks++;
        if (bp.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_cleared: got %b want 0", bp.proto_err);
        end
    endtask

    task automatic test_oversize();
        step(1'b1, 32'hFFFF_FFFF, 32'd40, 1'b0);
        n_checks++;
        if (obs() !== pk(1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0) || bp.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize: got %h err %b want %h err 1", obs(), bp.proto_err, pk(1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0));
        end
        step(1'b1, 32'h0, 32'd0, 1'b1);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_empty: out_valid got %b want 0", bp.out_valid);
        end
    endtask

    task automatic test_reset_discard();
        do_reset();
        step(1'b1, 32'h0001_FFFF, 32'd17, 1'b0);
        do_reset();
`ifdef BIT_PACKER_STATS_EN
        n_checks++;
        if (bp.total_bits !== 32'h0 || bp.word_count !== 32'h0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", bp.total_bits, bp.word_count);
        end
`endif
        step(1'b1, 32'h0, 32'd0, 1'b1);
        n_checks++;
        if (bp.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: out_valid got %b want 0", bp.out_valid);
        end
    endtask

`ifdef BIT_PACKER_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_00AB, 32'd8, 1'b0);
        n_checks++;
        if (bp.total_bits !== 32'd32 || bp.word_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_word: got %0d/%0d want 32/1", bp.total_bits, bp.word_count);
        end
        step(1'b1, 32'h0000_0001, 32'd5, 1'b1);
        n_checks++;
        if (bp.total_bits !== 32'd37 || bp.word_count !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_flush: got %0d/%0d want 37/2", bp.total_bits, bp.word_count);
        end
    endtask
`endif

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bp.enable      = 1'b0;
        bp.val         = 32'h0;
        bp.size_of_bit = 32'h0;
        bp.flush_bit   = 1'b0;
        @(negedge clk);
        test_reset();
        test_pack_bytes();
        test_flush_short();
        test_flush_split();
        test_boundaries();
        test_enable_low_flush();
        test_proto_err();
        test_oversize();
        test_reset_discard();
`ifdef BIT_PACKER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
